// File: rtl/washing_machine_prog.sv
// rtl/washing_machine_prog.sv - programmable multi-pass washing machine phase sequencer
module washing_machine_prog #(
  parameter int BASE_CYC = 1000000,
  parameter int FILL_S   = 120,
  parameter int WASH_S   = 300,
  parameter int RINSE_S  = 120,
  parameter int SPIN_S   = 60,
  parameter int MAX_WASH = 4,
  parameter int PW       = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    clk_freq,
  input  logic          coin_in,
  input  logic [PW-1:0] wash_count,
  input  logic          timer_pause,
  output logic          wash_done,
  output logic [2:0]    phase_o,
  output logic [PW-1:0] pass_o
);

  // Prescaler must reach 8*BASE_CYC-1 at the slowest divide (clk_freq=11)
  localparam int PSW  = $clog2(8 * BASE_CYC);
  localparam int MAX1 = (FILL_S > WASH_S) ? FILL_S : WASH_S;
  localparam int MAX2 = (RINSE_S > SPIN_S) ? RINSE_S : SPIN_S;
  localparam int MAXD = (MAX1 > MAX2) ? MAX1 : MAX2;
  // Phase counter only needs 0..MAXD-1; one extra bit holds the duration itself
  localparam int TW   = (MAXD < 2) ? 1 : $clog2(MAXD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_RINSE = 3'd3,
    S_SPIN  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          r_state, w_next;
  logic [PSW-1:0]  r_presc, w_presc_nx;
  logic [TW-1:0]   r_cnt,   w_cnt_nx;
  logic [PW-1:0]   r_pass,  w_pass_nx;
  logic [PW-1:0]   r_n,     w_n_nx;
  logic [1:0]      r_freq,  w_freq_nx;

  logic [PSW:0]    w_len_m1;
  logic [TW:0]     w_dur;
  logic [PW-1:0]   w_clamp;
  logic            w_run;
  logic            w_tick;
  logic            w_end;
  logic            w_start;

  // State and counter registers; everything clears on async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_cnt   <= '0;
      r_pass  <= '0;
      r_n     <= '0;
      r_freq  <= '0;
    end else begin
      r_state <= w_next;
      r_presc <= w_presc_nx;
      r_cnt   <= w_cnt_nx;
      r_pass  <= w_pass_nx;
      r_n     <= w_n_nx;
      r_freq  <= w_freq_nx;
    end
  end

  // Next-state logic: tick generation, phase timing, pass bookkeeping and run start
  always_comb begin
    w_next     = r_state;
    w_presc_nx = r_presc;
    w_cnt_nx   = r_cnt;
    w_pass_nx  = r_pass;
    w_n_nx     = r_n;
    w_freq_nx  = r_freq;

    w_len_m1 = ((PSW+1)'(BASE_CYC) << r_freq) - (PSW+1)'(1);

    case (r_state)
      S_FILL:  w_dur = (TW+1)'(FILL_S);
      S_WASH:  w_dur = (TW+1)'(WASH_S);
      S_RINSE: w_dur = (TW+1)'(RINSE_S);
      S_SPIN:  w_dur = (TW+1)'(SPIN_S);
      default: w_dur = (TW+1)'(1);
    endcase

    if (wash_count == '0) begin
      w_clamp = PW'(1);
    end else if (wash_count > PW'(MAX_WASH)) begin
      w_clamp = PW'(MAX_WASH);
    end else begin
      w_clamp = wash_count;
    end

    // Pause only freezes the timebase during SPIN
    w_run   = (r_state == S_FILL) || (r_state == S_WASH) || (r_state == S_RINSE) ||
              ((r_state == S_SPIN) && !timer_pause);
    w_tick  = w_run && ({1'b0, r_presc} == w_len_m1);
    w_end   = w_tick && ({1'b0, r_cnt} == (w_dur - (TW+1)'(1)));
    w_start = ((r_state == S_IDLE) || (r_state == S_DONE)) && coin_in;

    if (w_start) begin
      w_next     = S_FILL;
      w_freq_nx  = clk_freq;
      w_n_nx     = w_clamp;
      w_pass_nx  = PW'(1);
      w_presc_nx = '0;
      w_cnt_nx   = '0;
    end else if (w_end) begin
      w_presc_nx = '0;
      w_cnt_nx   = '0;
      case (r_state)
        S_FILL:  w_next = S_WASH;
        S_WASH:  w_next = S_RINSE;
        S_RINSE: begin
          if (r_pass < r_n) begin
            w_next    = S_WASH;
            w_pass_nx = r_pass + PW'(1);
          end else begin
            w_next = S_SPIN;
          end
        end
        S_SPIN:  w_next = S_DONE;
        default: w_next = r_state;
      endcase
    end else if (w_tick) begin
      w_presc_nx = '0;
      w_cnt_nx   = r_cnt + TW'(1);
    end else if (w_run) begin
      w_presc_nx = r_presc + PSW'(1);
    end
  end

  // Outputs decode registered state only
  always_comb begin
    wash_done = (r_state == S_DONE);
    phase_o   = r_state;
    pass_o    = r_pass;
  end

endmodule

// File: tb/tb_washing_machine_prog.sv
// tb/tb_washing_machine_prog.sv - scoreboard bench for washing_machine_prog
module tb_washing_machine_prog;
  localparam int BASE = 4;
  localparam int FS   = 2;
  localparam int WS   = 3;
  localparam int RS   = 2;
  localparam int SS   = 1;
  localparam int MW   = 4;
  localparam int PW   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    clk_freq = 2'b00;
  logic          coin_in = 1'b0;
  logic [PW-1:0] wash_count = '0;
  logic          timer_pause = 1'b0;
  logic          wash_done;
  logic [2:0]    phase_o;
  logic [PW-1:0] pass_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]    ph;
    logic [PW-1:0] pa;
    int            cyc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  washing_machine_prog #(
    .BASE_CYC(BASE), .FILL_S(FS), .WASH_S(WS), .RINSE_S(RS),
    .SPIN_S(SS), .MAX_WASH(MW), .PW(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_freq(clk_freq), .coin_in(coin_in),
    .wash_count(wash_count), .timer_pause(timer_pause),
    .wash_done(wash_done), .phase_o(phase_o), .pass_o(pass_o)
  );

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    coin_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (phase_o !== 3'd0) begin errors++; $display("FAIL reset_phase: got %0d want 0", phase_o); end
    checks++;
    if (pass_o !== '0) begin errors++; $display("FAIL reset_pass: got %0d want 0", pass_o); end
    checks++;
    if (wash_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", wash_done); end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (phase_o !== 3'd0 || pass_o !== '0 || wash_done !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL idle_hold: %0d non-idle cycles, want 0", bad); end
  endtask

  task automatic test_run(input string name, input logic [1:0] f, input logic [PW-1:0] wc,
                          input int n, input int sp_p, input int wa_p, input bit hold_coin);
    int L, cyc, total, pz, exp_total;
    bit paused, swapped;
    logic [2:0] prev;
    exp_t e;
    L = BASE << f;
    sb.push_back('{ph: 3'd2, pa: PW'(1), cyc: FS * L});
    for (int p = 1; p <= n; p++) begin
      sb.push_back('{ph: 3'd3, pa: PW'(p), cyc: WS * L});
      if (p < n) sb.push_back('{ph: 3'd2, pa: PW'(p + 1), cyc: RS * L});
      else       sb.push_back('{ph: 3'd4, pa: PW'(n), cyc: RS * L});
    end
    sb.push_back('{ph: 3'd5, pa: PW'(n), cyc: SS * L + sp_p});
    exp_total = (FS + n * (WS + RS) + SS) * L + sp_p;

    clk_freq = f;
    wash_count = wc;
    coin_in = 1'b1;
    @(posedge clk); #1;
    if (!hold_coin) coin_in = 1'b0;
    checks++;
    if (phase_o !== 3'd1 || pass_o !== PW'(1) || wash_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: phase=%0d pass=%0d done=%b want 1/1/0", name, phase_o, pass_o, wash_done);
    end
    prev = phase_o; cyc = 0; total = 0; pz = 0; paused = 0; swapped = 0;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      cyc++; total++;
      if (phase_o !== prev) begin
        e = sb.pop_front();
        checks++;
        if (phase_o !== e.ph || pass_o !== e.pa || cyc !== e.cyc) begin
          errors++;
          $display("FAIL %s_step: phase=%0d pass=%0d cycles=%0d want %0d/%0d/%0d",
                   name, phase_o, pass_o, cyc, e.ph, e.pa, e.cyc);
        end
        prev = phase_o;
        cyc = 0;
        if (!swapped) begin
          clk_freq = ~f;
          wash_count = wc + PW'(3);
          swapped = 1;
        end
        if (phase_o == 3'd4) coin_in = 1'b0;
      end
      if (pz > 0) begin
        pz--;
        if (pz == 0) timer_pause = 1'b0;
      end else if (!paused && cyc == 2 &&
                   ((phase_o == 3'd4 && sp_p > 0) || (phase_o == 3'd2 && wa_p > 0))) begin
        timer_pause = 1'b1;
        pz = (phase_o == 3'd4) ? sp_p : wa_p;
        paused = 1;
      end
      if (total > 3000) begin
        checks++; errors++;
        $display("FAIL %s_timeout: %0d cycles, %0d events outstanding", name, total, sb.size());
        sb.delete();
      end
    end
    timer_pause = 1'b0;
    coin_in = 1'b0;
    checks++;
    if (total !== exp_total) begin errors++; $display("FAIL %s_total: got %0d want %0d", name, total, exp_total); end
    checks++;
    if (wash_done !== 1'b1 || pass_o !== PW'(n)) begin
      errors++;
      $display("FAIL %s_done: done=%b pass=%0d want 1/%0d", name, wash_done, pass_o, n);
    end
  endtask

  task automatic test_done_restart();
    @(posedge clk); #1;
    checks++;
    if (wash_done !== 1'b1 || phase_o !== 3'd5) begin
      errors++; $display("FAIL done_hold: done=%b phase=%0d want 1/5", wash_done, phase_o);
    end
    clk_freq = 2'b00;
    wash_count = PW'(2);
    coin_in = 1'b1;
    @(posedge clk); #1;
    coin_in = 1'b0;
    checks++;
    if (phase_o !== 3'd1 || wash_done !== 1'b0 || pass_o !== PW'(1)) begin
      errors++;
      $display("FAIL restart: phase=%0d done=%b pass=%0d want 1/0/1", phase_o, wash_done, pass_o);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int bad;
    n = 0;
    while (phase_o !== 3'd3 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (phase_o !== 3'd3) begin errors++; $display("FAIL reach_rinse: phase=%0d want 3", phase_o); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (phase_o !== 3'd0 || pass_o !== '0 || wash_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: phase=%0d pass=%0d done=%b want 0/0/0", phase_o, pass_o, wash_done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (phase_o !== 3'd0 || pass_o !== '0 || wash_done !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL post_reset_idle: %0d non-idle cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_run("single",    2'b00, PW'(1), 1, 0,  0,  1'b0);
    test_run("fast2",     2'b11, PW'(2), 2, 0,  0,  1'b0);
    test_run("zero",      2'b00, PW'(0), 1, 0,  0,  1'b0);
    test_run("clamp",     2'b00, PW'(7), 4, 0,  0,  1'b1);
    test_run("spinpause", 2'b00, PW'(1), 1, 10, 0,  1'b0);
    test_run("washpause", 2'b00, PW'(1), 1, 0,  10, 1'b0);
    test_run("mid2",      2'b01, PW'(3), 3, 0,  0,  1'b0);
    test_done_restart();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/washing_machine_prog.md
Name: washing_machine_prog

Overview:
- Parametrised successor to the fixed-program washing-machine controller. Sequences FILL -> WASH -> RINSE -> SPIN with parameter-set phase durations, a programmable number of wash/rinse passes (1..MAX_WASH), and a per-run selectable clock frequency.
- Spin-phase pause behaves as in the current controller.
- Sits between the coin/button front panel and the valve/motor drivers. Exposes phase and pass index for the display.

Parameters:
- BASE_CYC, 1000000, clock cycles per 1 s tick at 1 MHz (clk_freq=00).
- FILL_S, 120, fill duration in ticks.
- WASH_S, 300, wash duration in ticks.
- RINSE_S, 120, rinse duration in ticks.
- SPIN_S, 60, spin duration in ticks.
- MAX_WASH, 4, maximum wash/rinse passes per run.
- PW, 3, width of wash_count and pass_o; must be >= clog2(MAX_WASH+1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_freq  in  2  frequency select: 00=1 MHz, 01=2 MHz, 10=4 MHz, 11=8 MHz.
- coin_in  in  1  level, coin deposited / start request.
- wash_count  in  PW  requested number of wash/rinse passes.
- timer_pause  in  1  level, pauses timing during SPIN only.
- wash_done  out  1  high while in DONE.
- phase_o  out  3  0=IDLE, 1=FILL, 2=WASH, 3=RINSE, 4=SPIN, 5=DONE.
- pass_o  out  PW  current pass number, 1-based; 0 in IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; prescaler, tick counter, pass and latched config cleared. Outputs: wash_done=0, phase_o=0, pass_o=0.
- Tick generation:
  - L = BASE_CYC << clk_freq_latched.
  - Prescaler counts 0..L-1; tick is a 1-cycle pulse when prescaler = L-1, then prescaler wraps to 0.
  - Prescaler width = clog2(8*BASE_CYC).
- Phase counter counts ticks 0..DUR-1. The phase ends on the tick at which the counter = DUR-1, so each phase lasts exactly DUR*L cycles.
- On every phase change, prescaler and phase counter clear to 0.
- Run start (IDLE or DONE, coin_in=1 at a clock edge):
  - Latch clk_freq.
  - Latch N = wash_count, clamped: 0 -> 1, >MAX_WASH -> MAX_WASH.
  - pass=1; state FILL at the same edge.
- clk_freq and wash_count changes mid-run are ignored until the next run start.
- Transitions:
  - FILL -> WASH.
  - WASH -> RINSE.
  - RINSE -> WASH with pass+1 if pass<N; otherwise RINSE -> SPIN.
  - SPIN -> DONE.
- DONE: wash_done=1, pass_o holds N. Stays in DONE until coin_in=1, which starts a new run directly (-> FILL, wash_done=0 at that edge).
- timer_pause:
  - In SPIN, while timer_pause=1, prescaler and phase counter hold their values.
  - On release, counting resumes with no loss or gain of cycles.
  - Ignored in all other states.
- coin_in held high during a run has no effect.
- Total run time from the FILL entry edge to the DONE entry edge = (FILL_S + N*(WASH_S+RINSE_S) + SPIN_S)*L cycles, plus paused cycles.
- Reset asserted mid-run aborts immediately to IDLE (async); no residual state survives.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.

Test Plan (bench parameters BASE_CYC=4, FILL_S=2, WASH_S=3, RINSE_S=2, SPIN_S=1, MAX_WASH=4):
1. Reset with coin_in=0 -> phase_o=0, pass_o=0, wash_done=0. Remains in IDLE for 100 cycles.
2. clk_freq=00, wash_count=1, coin_in pulsed 1 cycle -> FILL for 8 cycles, WASH 12, RINSE 8, SPIN 4. wash_done rises exactly 32 cycles after FILL entry.
3. clk_freq=11, wash_count=2 -> L=32. Sequence is FILL, WASH(pass 1), RINSE, WASH(pass 2), RINSE, SPIN. wash_done after 13*32=416 cycles.
4. wash_count=0 -> behaves as 1 (32 cycles at 00). wash_count=7 -> clamped to 4 passes, pass_o reaches 4, run takes 23 ticks.
5. timer_pause=1 for 10 cycles mid-SPIN -> DONE delayed by exactly 10 cycles. timer_pause=1 for 10 cycles during WASH -> no delay.
6. rst_n=0 mid-RINSE -> immediate IDLE with all outputs 0. clk_freq changed mid-run has no effect on timing. coin_in=1 in DONE restarts at FILL with wash_done=0.
